shift_sequencer: RTL

//   Multi-cycle shift unit controller for the ALU shift path (SLL/SRL/SRA).

---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle for the multi-cycle shift sequencer.
// The master side is the ALU op decode; the slave side is the sequencer itself.
interface shift_sequencer_if #(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [N-1:0]       req_x;
  logic [SHAMT_W-1:0] req_shamt;
  logic               resp_valid;
  logic               resp_ready;
  logic [N-1:0]       resp_z;
  logic               resp_err;

  modport master (
    output req_valid, req_op, req_x, req_shamt, resp_ready,
    input  req_ready, resp_valid, resp_z, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_x, req_shamt, resp_ready,
    output req_ready, resp_valid, resp_z, resp_err
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA shifter: one bit position per cycle, valid/ready in and out.
// Define SHIFT_ROR_EN to add rotate-right on op 11; otherwise op 11 returns resp_err.
module shift_sequencer #(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t                    state;
  logic signed [N-1:0]       acc;
  logic        [SHAMT_W-1:0] cnt;
  logic        [1:0]         op_q;
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic                      op_illegal;

  // One-position step of the selected shift; arithmetic right replicates the sign bit.
  function automatic logic signed [N-1:0] shift_step(input logic [1:0] op,
                                                     input logic signed [N-1:0] a);
    logic signed [N-1:0] r;
    case (op)
      OP_SLL:  r = {a[N-2:0], 1'b0};
      OP_SRL:  r = {1'b0, a[N-1:1]};
      OP_SRA:  r = {a[N-1], a[N-1:1]};
`ifdef SHIFT_ROR_EN
      OP_ROR:  r = {a[0], a[N-1:1]};
`else
      default: r = a;
`endif
    endcase
    return r;
  endfunction

`ifdef SHIFT_ROR_EN
  assign op_illegal = 1'b0;
`else
  assign op_illegal = (bus.req_op == OP_ROR);
`endif

  // req_ready is gated by rst_n so it drops the instant reset asserts.
  assign bus.req_ready  = rst_n && (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_z     = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      op_q         <= OP_SLL;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q <= bus.req_op;
            cnt  <= bus.req_shamt;
            busy <= 1'b1;
            if (op_illegal) begin
              acc          <= '0;
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state        <= DONE;
            end else begin
              acc        <= bus.req_x;
              resp_err_q <= 1'b0;
              if (bus.req_shamt != '0) begin
                state <= SHIFT;
              end else begin
                resp_valid_q <= 1'b1;
                state        <= DONE;
              end
            end
          end
        end

        // ---- shift stage: one position per cycle until cnt runs out ----
        SHIFT: begin
          acc <= shift_step(op_q, acc);
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            resp_valid_q <= 1'b1;
            state        <= DONE;
          end
        end

        // ---- result stage: acc/err held until the consumer takes them ----
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          resp_valid_q <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
